// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR-bank pulse driver: FSM state encodings,
// default pulse/settle timing and the timer width helper.
package sr_drv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_CHECK  = 2'd3
   } sr_state_e;

   localparam int PULSE_CYC_DEF  = 2;
   localparam int SETTLE_CYC_DEF = 1;

   // Width that holds the larger of the two phase lengths; never below 1 bit.
   function automatic int sr_cnt_width(input int pulse_cyc, input int settle_cyc);
      int m;
      m = (pulse_cyc > settle_cyc) ? pulse_cyc : settle_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the DRIVE and SETTLE phases; holds at zero
// instead of wrapping.
module sr_pulse_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives set/reset pulses into an SR flip-flop bank only where the read-back
// differs from the target, then checks the result. Optional: SR_PULSE_RETRY_EN.
module sr_pulse_driver
   import sr_drv_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PULSE_CYC  = PULSE_CYC_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_target,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CW = sr_cnt_width(PULSE_CYC, SETTLE_CYC);
   localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   sr_state_e        state_q, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] s_mask_q, s_mask_d;
   logic [WIDTH-1:0] r_mask_q, r_mask_d;
   logic             timer_load;
   logic [CW-1:0]    timer_val;
   logic             timer_zero;
   logic             mism;
`ifdef SR_PULSE_RETRY_EN
   logic             retry_q, retry_d;
`endif

   sr_pulse_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   assign mism = (q_fb != tgt_q);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      s_mask_d   = s_mask_q;
      r_mask_d   = r_mask_q;
      timer_load = 1'b0;
      timer_val  = '0;
`ifdef SR_PULSE_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               tgt_d    = req_target;
               s_mask_d = req_target & ~q_fb;
               r_mask_d = ~req_target & q_fb;
`ifdef SR_PULSE_RETRY_EN
               retry_d  = 1'b0;
`endif
               if ((s_mask_d | r_mask_d) == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d    = ST_DRIVE;
                  timer_load = 1'b1;
                  timer_val  = PULSE_LD;
               end
            end
         end
         ST_DRIVE: begin
            if (timer_zero) begin
               if (SETTLE_CYC == 0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d    = ST_SETTLE;
                  timer_load = 1'b1;
                  timer_val  = SETTLE_LD;
               end
            end
         end
         ST_SETTLE: begin
            if (timer_zero)
               state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
`ifdef SR_PULSE_RETRY_EN
            // One retry with masks rebuilt from the bank's present state.
            if (mism && !retry_q) begin
               retry_d  = 1'b1;
               s_mask_d = tgt_q & ~q_fb;
               r_mask_d = ~tgt_q & q_fb;
               if ((s_mask_d | r_mask_d) == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d    = ST_DRIVE;
                  timer_load = 1'b1;
                  timer_val  = PULSE_LD;
               end
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         tgt_q    <= '0;
         s_mask_q <= '0;
         r_mask_q <= '0;
`ifdef SR_PULSE_RETRY_EN
         retry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         s_mask_q <= s_mask_d;
         r_mask_q <= r_mask_d;
`ifdef SR_PULSE_RETRY_EN
         retry_q  <= retry_d;
`endif
      end
   end

   // Outputs decode the state register directly, so reset clears them at once.
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign s_out     = (state_q == ST_DRIVE) ? s_mask_q : '0;
   assign r_out     = (state_q == ST_DRIVE) ? r_mask_q : '0;
`ifdef SR_PULSE_RETRY_EN
   assign done      = (state_q == ST_CHECK) && (!mism || retry_q);
`else
   assign done      = (state_q == ST_CHECK);
`endif
   assign err       = done && mism;

endmodule
